// File: rtl/axi_slave_pkg.sv
// rtl/axi_slave_pkg.sv - shared types and helpers for the axi_slave_mem slice
package axi_slave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  function automatic int log2_strb(input int strobe_width);
    return $clog2(strobe_width);
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// rtl/axi_addr_gen.sv - next beat address and burst legality from AxADDR/AxLEN/AxSIZE/AxBURST
module axi_addr_gen
  import axi_slave_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int LEN_WIDTH    = 8,
  parameter int SIZE_WIDTH   = 3,
  parameter int BURST_WIDTH  = 2,
  parameter int STROBE_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  input  logic [SIZE_WIDTH-1:0]  size_i,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [ADDR_WIDTH-1:0]  next_addr_o,
  output logic                   err_o,
  output logic                   size_err_o
);

  localparam int LSB = log2_strb(STROBE_WIDTH);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] mask;
  logic                  wrap_len_ok;
  logic                  is_wrap;
  logic                  is_rsvd;

  always_comb begin
    step        = ADDR_WIDTH'(1) << size_i;
    incr        = addr_i + step;
    mask        = ((ADDR_WIDTH'(len_i) + 1'b1) << size_i) - 1'b1;
    wrap_len_ok = (len_i == LEN_WIDTH'(1)) || (len_i == LEN_WIDTH'(3)) ||
                  (len_i == LEN_WIDTH'(7)) || (len_i == LEN_WIDTH'(15));
    is_wrap     = (burst_i == BURST_WIDTH'(BURST_WRAP));
    is_rsvd     = (burst_i == BURST_WIDTH'(BURST_RSVD));
    size_err_o  = (size_i > SIZE_WIDTH'(LSB));
    err_o       = size_err_o || is_rsvd || (is_wrap && !wrap_len_ok);

    // Reserved bursts and illegal-length wraps fall back to incrementing.
    if (burst_i == BURST_WIDTH'(BURST_FIXED)) begin
      next_addr_o = addr_i;
    end else if (is_wrap && wrap_len_ok) begin
      next_addr_o = (addr_i & ~mask) | (incr & mask);
    end else begin
      next_addr_o = incr;
    end
  end

endmodule

// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI4 slave memory, concurrent write/read engines; AXI_SLAVE_MEM_DECERR_EN enables DECERR
module axi_slave_mem
  import axi_slave_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int LEN_WIDTH    = 8,
  parameter int SIZE_WIDTH   = 3,
  parameter int BURST_WIDTH  = 2,
  parameter int RESP_WIDTH   = 2,
  parameter int ID_WIDTH     = 4,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_WORDS    = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [LEN_WIDTH-1:0]    AWLEN,
  input  logic [SIZE_WIDTH-1:0]   AWSIZE,
  input  logic [BURST_WIDTH-1:0]  AWBURST,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [STROBE_WIDTH-1:0] WSTRB,
  input  logic                    WLAST,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [RESP_WIDTH-1:0]   BRESP,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [LEN_WIDTH-1:0]    ARLEN,
  input  logic [SIZE_WIDTH-1:0]   ARSIZE,
  input  logic [BURST_WIDTH-1:0]  ARBURST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [RESP_WIDTH-1:0]   RRESP,
  output logic                    RLAST
);

  localparam int LSB = log2_strb(STROBE_WIDTH);
  localparam int WW  = ADDR_WIDTH - LSB;
  localparam int IW  = $clog2(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  wr_state_t              w_state_q;
  logic                   awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0]    awid_q, bid_q;
  logic [RESP_WIDTH-1:0]  bresp_q;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic [LEN_WIDTH-1:0]   awlen_q, wbeat_q;
  logic [SIZE_WIDTH-1:0]  awsize_q;
  logic [BURST_WIDTH-1:0] awburst_q;
  logic                   wslv_q, wdec_q, wslv_d, wdec_d;
  logic                   w_err, w_size_err, w_hs, w_last_beat, w_dec, mem_we;
  logic [WW-1:0]          w_word;
  logic [IW-1:0]          w_idx;

  axi_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .SIZE_WIDTH(SIZE_WIDTH),
    .BURST_WIDTH(BURST_WIDTH), .STROBE_WIDTH(STROBE_WIDTH)
  ) u_wr_gen (
    .addr_i(waddr_q), .len_i(awlen_q), .size_i(awsize_q), .burst_i(awburst_q),
    .next_addr_o(waddr_d), .err_o(w_err), .size_err_o(w_size_err)
  );

  always_comb begin
    w_hs        = (w_state_q == W_DATA) && WVALID && wready_q;
    w_last_beat = (wbeat_q == awlen_q);
    w_word      = WW'(waddr_q >> LSB);
    w_idx       = IW'(w_word % WW'(MEM_WORDS));
`ifdef AXI_SLAVE_MEM_DECERR_EN
    w_dec       = (w_word >= WW'(MEM_WORDS));
`else
    w_dec       = 1'b0;
`endif
    // WLAST disagreeing with the beat count flags the burst but never ends it early.
    wslv_d      = wslv_q || w_err || (WLAST != w_last_beat);
    wdec_d      = wdec_q || w_dec;
    mem_we      = w_hs && !w_size_err && !w_dec;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      awid_q    <= '0;
      waddr_q   <= '0;
      awlen_q   <= '0;
      wbeat_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      wslv_q    <= 1'b0;
      wdec_q    <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (AWVALID && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            awid_q    <= AWID;
            waddr_q   <= AWADDR;
            awlen_q   <= AWLEN;
            awsize_q  <= AWSIZE;
            awburst_q <= AWBURST;
            wbeat_q   <= '0;
            wslv_q    <= 1'b0;
            wdec_q    <= 1'b0;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            waddr_q <= waddr_d;
            wbeat_q <= wbeat_q + 1'b1;
            wslv_q  <= wslv_d;
            wdec_q  <= wdec_d;
            if (w_last_beat) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bid_q     <= awid_q;
              bresp_q   <= wdec_d ? RESP_WIDTH'(RESP_DECERR) :
                           wslv_d ? RESP_WIDTH'(RESP_SLVERR) : RESP_WIDTH'(RESP_OKAY);
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int i = 0; i < STROBE_WIDTH; i++) begin
        if (WSTRB[i]) mem[w_idx][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

  rd_state_t              r_state_q;
  logic                   arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0]    rid_q;
  logic [DATA_WIDTH-1:0]  rdata_q, r_data_d;
  logic [RESP_WIDTH-1:0]  rresp_q, r_resp_d;
  logic [ADDR_WIDTH-1:0]  raddr_q, raddr_d, r_beat_addr;
  logic [LEN_WIDTH-1:0]   arlen_q, rbeat_q, r_len;
  logic [SIZE_WIDTH-1:0]  arsize_q, r_size;
  logic [BURST_WIDTH-1:0] arburst_q, r_burst;
  logic                   r_idle, r_err, r_size_err, r_dec;
  logic [WW-1:0]          r_word;
  logic [IW-1:0]          r_idx;

  // In idle the generator judges the incoming AR fields so beat 0 already carries its response.
  assign r_idle  = (r_state_q == R_IDLE);
  assign r_len   = r_idle ? ARLEN   : arlen_q;
  assign r_size  = r_idle ? ARSIZE  : arsize_q;
  assign r_burst = r_idle ? ARBURST : arburst_q;

  axi_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .SIZE_WIDTH(SIZE_WIDTH),
    .BURST_WIDTH(BURST_WIDTH), .STROBE_WIDTH(STROBE_WIDTH)
  ) u_rd_gen (
    .addr_i(raddr_q), .len_i(r_len), .size_i(r_size), .burst_i(r_burst),
    .next_addr_o(raddr_d), .err_o(r_err), .size_err_o(r_size_err)
  );

  always_comb begin
    r_beat_addr = r_idle ? ARADDR : raddr_d;
    r_word      = WW'(r_beat_addr >> LSB);
    r_idx       = IW'(r_word % WW'(MEM_WORDS));
`ifdef AXI_SLAVE_MEM_DECERR_EN
    r_dec       = (r_word >= WW'(MEM_WORDS));
`else
    r_dec       = 1'b0;
`endif
    r_data_d    = (r_size_err || r_dec) ? '0 : mem[r_idx];
    r_resp_d    = r_dec ? RESP_WIDTH'(RESP_DECERR) :
                  r_err ? RESP_WIDTH'(RESP_SLVERR) : RESP_WIDTH'(RESP_OKAY);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      raddr_q   <= '0;
      arlen_q   <= '0;
      rbeat_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ARVALID && arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= ARID;
            rlast_q   <= (ARLEN == '0);
            rdata_q   <= r_data_d;
            rresp_q   <= r_resp_d;
            raddr_q   <= ARADDR;
            arlen_q   <= ARLEN;
            arsize_q  <= ARSIZE;
            arburst_q <= ARBURST;
            rbeat_q   <= '0;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY && rvalid_q) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              rbeat_q <= rbeat_q + 1'b1;
              rlast_q <= ((rbeat_q + 1'b1) == arlen_q);
              raddr_q <= raddr_d;
              rdata_q <= r_data_d;
              rresp_q <= r_resp_d;
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - scoreboard bench for axi_slave_mem
module tb_axi_slave_mem;

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
  localparam int LIM = 100;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        AWVALID, AWREADY;
  logic [3:0]  AWID;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        BVALID, BREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [3:0]  ARID;
  logic [15:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        RVALID, RREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;

  always #5 ACLK = ~ACLK;

  axi_slave_mem dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
    .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARADDR(ARADDR),
    .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0]  exp_b[$];
  logic [31:0] exp_rdata[$];
  logic [1:0]  exp_rresp[$];
  logic [31:0] wbuf[16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic setw(input logic [31:0] a, b, c, d);
    wbuf[0] = a; wbuf[1] = b; wbuf[2] = c; wbuf[3] = d;
  endtask

  task automatic push_r(input logic [31:0] d, input logic [1:0] r);
    exp_rdata.push_back(d);
    exp_rresp.push_back(r);
  endtask

  task automatic wr(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                    input int early_last, input int bstall);
    int n;
    logic [5:0] e;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < LIM) begin @(negedge ACLK); n++; end
    if (n >= LIM) check("aw_wait", 0, 1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      WDATA = wbuf[b]; WSTRB = strb; WVALID = 1'b1;
      WLAST = (early_last >= 0) ? (b == early_last) : (b == int'(len));
      n = 0;
      while (!WREADY && n < LIM) begin @(negedge ACLK); n++; end
      if (n >= LIM) check("w_wait", 0, 1);
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    n = 0;
    while (!BVALID && n < LIM) begin @(negedge ACLK); n++; end
    if (n >= LIM) check("b_wait", 0, 1);
    e = exp_b.pop_front();
    for (int s = 0; s < bstall; s++) begin
      check("b_stall", {BVALID, BID, BRESP}, {1'b1, e});
      @(negedge ACLK);
    end
    check("bid", BID, e[5:2]);
    check("bresp", BRESP, e[1:0]);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    check("b_drop", BVALID, 0);
  endtask

  task automatic rd(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int n;
    int beat;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < LIM) begin @(negedge ACLK); n++; end
    if (n >= LIM) check("ar_wait", 0, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    RREADY = 1'b0;
    beat = 0;
    n = 0;
    while (beat <= int'(len) && n < LIM) begin
      RREADY = toggle ? ~RREADY : 1'b1;
      if (RVALID) begin
        if (exp_rdata.size() == 0) begin
          check("r_extra", 1, 0);
          break;
        end
        check("rdata", RDATA, exp_rdata[0]);
        check("rresp", RRESP, exp_rresp[0]);
        check("rid", RID, id);
        check("rlast", RLAST, beat == int'(len));
        if (RREADY) begin
          void'(exp_rdata.pop_front());
          void'(exp_rresp.pop_front());
          beat++;
        end
      end
      @(negedge ACLK);
      n++;
    end
    RREADY = 1'b0;
    if (beat <= int'(len)) check("r_beats", beat, int'(len) + 1);
    check("r_done", RVALID, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    ARESET = 1'b1;
    AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
    WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; BREADY = 0;
    ARVALID = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; RREADY = 0;
    repeat (3) @(negedge ACLK);
    check("rst_ctrl", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST}, 6'b0);
    check("rst_data", {BID, BRESP, RID, RRESP, RDATA}, '0);
    ARESET = 1'b0;
    check("rst_rel_ready", {AWREADY, ARREADY}, 2'b00);
    @(negedge ACLK);
    check("post_rst_ready", {AWREADY, ARREADY}, 2'b11);

    // INCR write and read back
    setw(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    exp_b.push_back({4'd5, OKAY});
    wr(4'd5, 16'h0010, 8'd3, 3'd2, INCR, 4'hF, -1, 0);
    for (int i = 0; i < 4; i++) push_r(32'hA0 + i, OKAY);
    rd(4'd7, 16'h0010, 8'd3, 3'd2, INCR, 1'b0);

    // WRAP write lands at 0x18,0x1C,0x10,0x14
    setw(32'd1, 32'd2, 32'd3, 32'd4);
    exp_b.push_back({4'd1, OKAY});
    wr(4'd1, 16'h0018, 8'd3, 3'd2, WRAP, 4'hF, -1, 0);
    push_r(32'd3, OKAY); push_r(32'd4, OKAY); push_r(32'd1, OKAY); push_r(32'd2, OKAY);
    rd(4'd2, 16'h0010, 8'd3, 3'd2, INCR, 1'b0);

    // FIXED burst with partial strobes
    setw(32'hFFFF_FFFF, 0, 0, 0);
    exp_b.push_back({4'd3, OKAY});
    wr(4'd3, 16'h0040, 8'd0, 3'd2, INCR, 4'hF, -1, 0);
    setw(32'h0, 32'h0, 0, 0);
    exp_b.push_back({4'd4, OKAY});
    wr(4'd4, 16'h0040, 8'd1, 3'd2, FIXED, 4'b0101, -1, 0);
    push_r(32'hFF00_FF00, OKAY);
    rd(4'd4, 16'h0040, 8'd0, 3'd2, INCR, 1'b0);

    // B stall and R backpressure
    setw(32'hCAFE_0001, 0, 0, 0);
    exp_b.push_back({4'd9, OKAY});
    wr(4'd9, 16'h0050, 8'd0, 3'd2, INCR, 4'hF, -1, 5);
    push_r(32'd3, OKAY); push_r(32'd4, OKAY); push_r(32'd1, OKAY); push_r(32'd2, OKAY);
    rd(4'd3, 16'h0010, 8'd3, 3'd2, INCR, 1'b1);

    // Early WLAST: all four beats still written, SLVERR
    setw(32'd11, 32'd12, 32'd13, 32'd14);
    exp_b.push_back({4'd2, SLVERR});
    wr(4'd2, 16'h0080, 8'd3, 3'd2, INCR, 4'hF, 1, 0);
    for (int i = 0; i < 4; i++) push_r(32'd11 + i, OKAY);
    rd(4'd6, 16'h0080, 8'd3, 3'd2, INCR, 1'b0);

    // Reserved burst behaves as INCR with SLVERR
    setw(32'd21, 32'd22, 0, 0);
    exp_b.push_back({4'hA, SLVERR});
    wr(4'hA, 16'h0060, 8'd1, 3'd2, RSVD, 4'hF, -1, 0);
    push_r(32'd21, OKAY); push_r(32'd22, OKAY);
    rd(4'hB, 16'h0060, 8'd1, 3'd2, INCR, 1'b0);
    push_r(32'd21, SLVERR); push_r(32'd22, SLVERR);
    rd(4'hC, 16'h0060, 8'd1, 3'd2, RSVD, 1'b0);

    // Oversized AxSIZE reads zero with SLVERR
    push_r(32'd0, SLVERR);
    rd(4'hD, 16'h0010, 8'd0, 3'd3, INCR, 1'b0);

    // Out-of-range address
    setw(32'h1234_5678, 0, 0, 0);
    exp_b.push_back({4'h0, OKAY});
    wr(4'h0, 16'h0000, 8'd0, 3'd2, INCR, 4'hF, -1, 0);
`ifdef AXI_SLAVE_MEM_DECERR_EN
    push_r(32'd0, DECERR);
`else
    push_r(32'h1234_5678, OKAY);
`endif
    rd(4'hE, 16'h1000, 8'd0, 3'd2, INCR, 1'b0);

    // Reset mid-read
    ARID = 4'h1; ARADDR = 16'h0010; ARLEN = 8'd3; ARSIZE = 3'd2; ARBURST = INCR; ARVALID = 1'b1;
    for (int n = 0; n < LIM && !ARREADY; n++) @(negedge ACLK);
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("mr_rvalid", RVALID, 1);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("mr_rst_rvalid", {RVALID, ARREADY}, 2'b00);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("mr_arready", ARREADY, 1);
    push_r(32'd3, OKAY);
    rd(4'h2, 16'h0010, 8'd0, 3'd2, INCR, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
